// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response bus from the execute stage and word-port memory bus.
interface lsu_req_if #(
    parameter int ADDR_BUS_WIDTH = 32,
    parameter int DATA_BUS_WIDTH = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [1:0]                req_size;
    logic                      req_unsigned;
    logic [ADDR_BUS_WIDTH-1:0] req_addr;
    logic [DATA_BUS_WIDTH-1:0] req_wdata;
    logic                      resp_valid;
    logic [DATA_BUS_WIDTH-1:0] resp_rdata;
    logic                      resp_error;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

interface lsu_mem_if #(
    parameter int ADDR_BUS_WIDTH = 32,
    parameter int DATA_BUS_WIDTH = 32
);
    logic [ADDR_BUS_WIDTH-1:0] mem_addr;
    logic [DATA_BUS_WIDTH-1:0] mem_write_data;
    logic                      mem_write_en;
    logic [DATA_BUS_WIDTH-1:0] mem_read_data;

    modport master (
        output mem_addr, mem_write_data, mem_write_en,
        input  mem_read_data
    );

    modport slave (
        input  mem_addr, mem_write_data, mem_write_en,
        output mem_read_data
    );
endinterface

// File: rtl/lsu_data_align.sv
// Big-endian lane selection: load extraction/extension and sub-word store merge.
module lsu_data_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [31:0] rd_word,
    input  logic [31:0] st_data,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rd_word[31:24];
        case (offset)
            2'd0: byte_sel = rd_word[31:24];
            2'd1: byte_sel = rd_word[23:16];
            2'd2: byte_sel = rd_word[15:8];
            2'd3: byte_sel = rd_word[7:0];
            default: byte_sel = rd_word[31:24];
        endcase
        half_sel = offset[1] ? rd_word[15:0] : rd_word[31:16];

        case (size)
            SIZE_BYTE: load_val = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_val = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default:   load_val = rd_word;
        endcase

        // Untouched lanes keep the word just read from memory.
        store_word = rd_word;
        case (size)
            SIZE_BYTE: begin
                case (offset)
                    2'd0: store_word[31:24] = st_data[7:0];
                    2'd1: store_word[23:16] = st_data[7:0];
                    2'd2: store_word[15:8]  = st_data[7:0];
                    2'd3: store_word[7:0]   = st_data[7:0];
                    default: store_word = rd_word;
                endcase
            end
            SIZE_HALF: begin
                if (offset[1]) store_word[15:0]  = st_data[15:0];
                else           store_word[31:16] = st_data[15:0];
            end
            default: store_word = st_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store master for a big-endian word-port memory; sub-word stores use read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_BUS_WIDTH = 32,
    parameter int DATA_BUS_WIDTH = 32,
    parameter int MEM_BYTES      = 64
) (
    input  logic      clk,
    input  logic      rst,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    localparam logic [ADDR_BUS_WIDTH-1:0] LAST_WORD_ADDR = ADDR_BUS_WIDTH'(MEM_BYTES - 4);

    logic [1:0]                state_q, state_d;
    logic [ADDR_BUS_WIDTH-1:0] addr_q, addr_d;
    size_e                     size_q, size_d;
    logic                      write_q, write_d;
    logic                      unsigned_q, unsigned_d;
    logic                      err_q, err_d;
    logic [DATA_BUS_WIDTH-1:0] store_word_q, store_word_d;
    logic [DATA_BUS_WIDTH-1:0] rdata_q, rdata_d;

    logic                      accept;
    logic                      misalign;
    logic                      req_err;
    logic [ADDR_BUS_WIDTH-1:0] aligned_req_addr;
    logic [31:0]               load_val;
    logic [31:0]               merged_word;

    lsu_data_align u_align (
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .rd_word     (mem.mem_read_data),
        .st_data     (store_word_q),
        .load_val    (load_val),
        .store_word  (merged_word)
    );

    always_comb begin
        accept           = req.req_valid && (state_q == ST_IDLE);
        aligned_req_addr = {req.req_addr[ADDR_BUS_WIDTH-1:2], 2'b00};
        case (size_e'(req.req_size))
            SIZE_HALF: misalign = req.req_addr[0];
            SIZE_WORD: misalign = (req.req_addr[1:0] != 2'b00);
            SIZE_RSVD: misalign = 1'b1;
            default:   misalign = 1'b0;
        endcase
        req_err = misalign || (aligned_req_addr > LAST_WORD_ADDR);
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        write_d      = write_q;
        unsigned_d   = unsigned_q;
        err_d        = err_q;
        store_word_d = store_word_q;
        rdata_d      = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d       = req.req_addr;
                    size_d       = size_e'(req.req_size);
                    write_d      = req.req_write;
                    unsigned_d   = req.req_unsigned;
                    err_d        = req_err;
                    store_word_d = req.req_wdata;
                    rdata_d      = '0;
                    if (req_err)
                        state_d = ST_RESP;
                    else if (req.req_write && (size_e'(req.req_size) == SIZE_WORD))
                        state_d = ST_WRITE;
                    else
                        state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Stores reuse store_word as the merge result once the lanes are combined.
                if (write_q) begin
                    store_word_d = merged_word;
                    state_d      = ST_WRITE;
                end else begin
                    rdata_d = load_val;
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
        addr_q       <= addr_d;
        size_q       <= size_d;
        write_q      <= write_d;
        unsigned_q   <= unsigned_d;
        store_word_q <= store_word_d;
    end

    assign req.req_ready      = (state_q == ST_IDLE);
    assign req.resp_valid     = (state_q == ST_RESP);
    assign req.resp_error     = (state_q == ST_RESP) && err_q;
    assign req.resp_rdata     = (state_q == ST_RESP) ? rdata_q : '0;
    assign mem.mem_addr       = ((state_q == ST_ACCESS) || (state_q == ST_WRITE)) ?
                                {addr_q[ADDR_BUS_WIDTH-1:2], 2'b00} : '0;
    assign mem.mem_write_data = (state_q == ST_WRITE) ? store_word_q : '0;
    assign mem.mem_write_en   = (state_q == ST_WRITE) && !rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a falling-edge word memory model.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_req_if #(.ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32)) rq ();
    lsu_mem_if #(.ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32)) mb ();

    load_store_unit #(
        .ADDR_BUS_WIDTH (32),
        .DATA_BUS_WIDTH (32),
        .MEM_BYTES      (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .req (rq.slave),
        .mem (mb.master)
    );

    logic [31:0] mem [0:15];
    assign mb.mem_read_data = mem[mb.mem_addr[5:2]];
    always @(negedge clk) if (mb.mem_write_en) mem[mb.mem_addr[5:2]] <= mb.mem_write_data;

    int n_vec = 0;
    int n_err = 0;

    int          o_lat, o_nwr;
    logic [31:0] o_wa, o_wd, o_rd;
    logic        o_er;

    task automatic wait_ready();
        int guard = 0;
        @(negedge clk);
        while (!rq.req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd);
        wait_ready();
        rq.req_write = w; rq.req_size = sz; rq.req_unsigned = u;
        rq.req_addr = a; rq.req_wdata = wd; rq.req_valid = 1'b1;
        @(posedge clk); #1;
        rq.req_valid = 1'b0;
        o_lat = 0; o_nwr = 0; o_wa = '0; o_wd = '0; o_rd = '0; o_er = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (mb.mem_write_en) begin
                o_nwr++; o_wa = mb.mem_addr; o_wd = mb.mem_write_data;
            end
            if (rq.resp_valid) begin
                o_lat = k; o_rd = rq.resp_rdata; o_er = rq.resp_error;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({rq.req_ready, rq.resp_valid, rq.resp_error} !== 3'b100) begin
            n_err++; $display("FAIL reset_ctrl: got rdy/vld/err=%b expected 100", {rq.req_ready, rq.resp_valid, rq.resp_error});
        end
        n_vec++;
        if (rq.resp_rdata !== 32'h0 || mb.mem_addr !== 32'h0 || mb.mem_write_data !== 32'h0 || mb.mem_write_en !== 1'b0) begin
            n_err++; $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h we=%b expected all zero",
                              rq.resp_rdata, mb.mem_addr, mb.mem_write_data, mb.mem_write_en);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        int pulses = 0;
        wait_ready();
        rq.req_write = 1'b1; rq.req_size = 2'b00; rq.req_unsigned = 1'b0;
        rq.req_addr = 32'd5; rq.req_wdata = 32'h12345677; rq.req_valid = 1'b1;
        @(posedge clk); #1;
        rq.req_valid = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (mb.mem_write_en !== 1'b1) begin
            n_err++; $display("FAIL rstw_in_write: got we=%b expected 1", mb.mem_write_en);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (mb.mem_write_en !== 1'b0) begin
            n_err++; $display("FAIL rstw_we_gated: got we=%b expected 0", mb.mem_write_en);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++;
        if (rq.req_ready !== 1'b1) begin
            n_err++; $display("FAIL rstw_ready: got %b expected 1", rq.req_ready);
        end
        for (int k = 0; k < 3; k++) begin
            if (rq.resp_valid) pulses++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (pulses != 0) begin
            n_err++; $display("FAIL rstw_no_resp: got %0d resp pulses expected 0", pulses);
        end
        n_vec++;
        if (mem[1] !== 32'h33333333) begin
            n_err++; $display("FAIL rstw_mem: got %h expected 33333333", mem[1]);
        end
    endtask

    task automatic test_word_load();
        do_req(1'b0, 2'b10, 1'b0, 32'd8, 32'h0);
        n_vec++;
        if (o_rd !== 32'hAAAAAAAA || o_lat != 2 || o_nwr != 0 || o_er !== 1'b0) begin
            n_err++; $display("FAIL word_load8: got rd=%h lat=%0d wr=%0d err=%b expected AAAAAAAA 2 0 0", o_rd, o_lat, o_nwr, o_er);
        end
        do_req(1'b0, 2'b10, 1'b1, 32'd60, 32'h0);
        n_vec++;
        if (o_rd !== 32'h5A5A0001 || o_er !== 1'b0 || o_lat != 2) begin
            n_err++; $display("FAIL word_load60: got rd=%h err=%b lat=%0d expected 5A5A0001 0 2", o_rd, o_er, o_lat);
        end
    endtask

    task automatic test_byte_load();
        logic [31:0] addr_t [3] = '{32'd9, 32'd9, 32'd3};
        logic        uns_t  [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] exp_t  [3] = '{32'hFFFFFFAA, 32'h000000AA, 32'h0000000A};
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, 2'b00, uns_t[i], addr_t[i], 32'h0);
            n_vec++;
            if (o_rd !== exp_t[i] || o_lat != 2 || o_er !== 1'b0) begin
                n_err++; $display("FAIL byte_load[%0d]: got rd=%h lat=%0d err=%b expected %h 2 0", i, o_rd, o_lat, o_er, exp_t[i]);
            end
        end
        do_req(1'b0, 2'b00, 1'b1, 32'd63, 32'h0);
        n_vec++;
        if (o_rd !== 32'h00000001 || o_er !== 1'b0) begin
            n_err++; $display("FAIL byte_load63: got rd=%h err=%b expected 00000001 0", o_rd, o_er);
        end
    endtask

    task automatic test_byte_store();
        do_req(1'b1, 2'b00, 1'b0, 32'd5, 32'h12345677);
        n_vec++;
        if (o_nwr != 1 || o_wa !== 32'd4 || o_wd !== 32'h33773333) begin
            n_err++; $display("FAIL byte_store_bus: got pulses=%0d addr=%h data=%h expected 1 4 33773333", o_nwr, o_wa, o_wd);
        end
        n_vec++;
        if (o_lat != 3 || o_er !== 1'b0 || o_rd !== 32'h0) begin
            n_err++; $display("FAIL byte_store_resp: got lat=%0d err=%b rd=%h expected 3 0 0", o_lat, o_er, o_rd);
        end
        n_vec++;
        if (mem[1] !== 32'h33773333) begin
            n_err++; $display("FAIL byte_store_mem: got %h expected 33773333", mem[1]);
        end
    endtask

    task automatic test_half();
        do_req(1'b1, 2'b01, 1'b0, 32'd2, 32'h0000BEEF);
        n_vec++;
        if (mem[0] !== 32'h0000BEEF || o_nwr != 1 || o_lat != 3) begin
            n_err++; $display("FAIL half_store: got mem0=%h pulses=%0d lat=%0d expected 0000BEEF 1 3", mem[0], o_nwr, o_lat);
        end
        do_req(1'b0, 2'b01, 1'b0, 32'd2, 32'h0);
        n_vec++;
        if (o_rd !== 32'hFFFFBEEF) begin
            n_err++; $display("FAIL half_load_s: got %h expected FFFFBEEF", o_rd);
        end
        do_req(1'b0, 2'b01, 1'b1, 32'd2, 32'h0);
        n_vec++;
        if (o_rd !== 32'h0000BEEF) begin
            n_err++; $display("FAIL half_load_u: got %h expected 0000BEEF", o_rd);
        end
    endtask

    task automatic test_word_store();
        do_req(1'b1, 2'b10, 1'b0, 32'd12, 32'hCAFEF00D);
        n_vec++;
        if (o_lat != 2 || o_nwr != 1 || o_wa !== 32'd12 || o_wd !== 32'hCAFEF00D || mem[3] !== 32'hCAFEF00D) begin
            n_err++; $display("FAIL word_store: got lat=%0d pulses=%0d addr=%h data=%h mem3=%h expected 2 1 c cafef00d cafef00d",
                              o_lat, o_nwr, o_wa, o_wd, mem[3]);
        end
    endtask

    task automatic test_errors();
        logic        w_t    [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0]  size_t [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        logic [31:0] addr_t [4] = '{32'd6, 32'd3, 32'd0, 32'd64};
        for (int i = 0; i < 4; i++) begin
            do_req(w_t[i], size_t[i], 1'b0, addr_t[i], 32'hFFFFFFFF);
            n_vec++;
            if (o_er !== 1'b1 || o_lat != 1 || o_nwr != 0 || o_rd !== 32'h0) begin
                n_err++; $display("FAIL error[%0d]: got err=%b lat=%0d pulses=%0d rd=%h expected 1 1 0 0", i, o_er, o_lat, o_nwr, o_rd);
            end
        end
        n_vec++;
        if (mem[0] !== 32'h0000BEEF || mem[1] !== 32'h33773333) begin
            n_err++; $display("FAIL error_mem: got mem0=%h mem1=%h expected 0000BEEF 33773333", mem[0], mem[1]);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int wr = 0;
        logic rdy1 = 1'b1;
        logic [31:0] bad_rd = '0;
        wait_ready();
        rq.req_write = 1'b0; rq.req_size = 2'b10; rq.req_unsigned = 1'b0;
        rq.req_addr = 32'd4; rq.req_wdata = 32'h0; rq.req_valid = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 5; k++) begin
            if (k == 1) rdy1 = rq.req_ready;
            if (mb.mem_write_en) wr++;
            if (rq.resp_valid) begin
                pulses++;
                if (rq.resp_rdata !== 32'h33773333) bad_rd = rq.resp_rdata;
            end
            if (k == 5) rq.req_valid = 1'b0;
            else begin
                @(posedge clk); #1;
            end
        end
        n_vec++;
        if (pulses != 2 || wr != 0) begin
            n_err++; $display("FAIL b2b_count: got resp=%0d writes=%0d expected 2 0", pulses, wr);
        end
        n_vec++;
        if (bad_rd !== 32'h0 || rdy1 !== 1'b0) begin
            n_err++; $display("FAIL b2b_data: got bad_rd=%h busy_ready=%b expected 0 0", bad_rd, rdy1);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0]  = 32'h0000000A;
        mem[1]  = 32'h33333333;
        mem[2]  = 32'hAAAAAAAA;
        mem[15] = 32'h5A5A0001;
        rq.req_valid = 1'b0; rq.req_write = 1'b0; rq.req_size = 2'b00;
        rq.req_unsigned = 1'b0; rq.req_addr = '0; rq.req_wdata = '0;
        test_reset();
        test_reset_mid_write();
        test_word_load();
        test_byte_load();
        test_byte_store();
        test_half();
        test_word_store();
        test_errors();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000, expected completion");
        $fatal(1);
    end

endmodule
